// File: rtl/branch_predictor_gshare.sv
// Tagged direct-mapped BTB plus 2-bit saturating PHT, bimodal or gshare indexed,
// with speculative global history, mispredict recovery and saturating perf counters.
module branch_predictor_gshare #(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int HIST_W  = 6,
    parameter int MODE    = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic [DATA_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_mispredict,
    output logic [CNT_W-1:0]  perf_lookups,
    output logic [CNT_W-1:0]  perf_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] btb_valid_r;
    logic [TAG_W-1:0]   btb_tag_r    [ENTRIES];
    logic [DATA_W-1:0]  btb_target_r [ENTRIES];
    logic [1:0]         pht_r        [ENTRIES];
    logic [HIST_W-1:0]  ghr_r;
    logic [HIST_W-1:0]  ghr_next_s;
    logic [CNT_W-1:0]   perf_lookups_r;
    logic [CNT_W-1:0]   perf_mispred_r;

    logic [IDX_W-1:0]   bidx_s, pidx_s, uidx_s, upidx_s;
    logic [TAG_W-1:0]   tag_s, utag_s;
    logic               hit_s, recover_s;

    // Shift-left-and-insert works for any HIST_W, including 1 where no old bits survive.
    function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h, input logic b);
        return (h << 1) | HIST_W'(b);
    endfunction

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? c : c - 2'b01;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign bidx_s    = if_pc[IDX_W+1:2];
    assign tag_s     = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign pidx_s    = (MODE != 0) ? (bidx_s ^ IDX_W'(ghr_r)) : bidx_s;
    assign uidx_s    = upd_pc[IDX_W+1:2];
    assign utag_s    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upidx_s   = (MODE != 0) ? (uidx_s ^ IDX_W'(upd_ghr)) : uidx_s;
    assign hit_s     = btb_valid_r[bidx_s] && (btb_tag_r[bidx_s] == tag_s);
    assign recover_s = upd_valid & upd_mispredict;

    assign pred_taken   = hit_s & pht_r[pidx_s][1];
    assign pred_target  = pred_taken ? btb_target_r[bidx_s] : if_pc + DATA_W'(4);
    assign pred_ghr     = ghr_r;
    assign perf_lookups = perf_lookups_r;
    assign perf_mispred = perf_mispred_r;

    // Next history: recovery wins over speculative shift; bimodal keeps history at zero.
    always_comb begin
        ghr_next_s = ghr_r;
        if (MODE == 0) begin
            ghr_next_s = HIST_W'(0);
        end else if (recover_s) begin
            ghr_next_s = hist_shift(upd_ghr, upd_taken);
        end else if (enable && hit_s) begin
            ghr_next_s = hist_shift(ghr_r, pred_taken);
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    // History and performance counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ghr_r          <= HIST_W'(0);
            perf_lookups_r <= CNT_W'(0);
            perf_mispred_r <= CNT_W'(0);
        end else begin
            ghr_r <= ghr_next_s;
            if (enable && hit_s) begin
                perf_lookups_r <= sat_inc(perf_lookups_r);
            end
            if (recover_s) begin
                perf_mispred_r <= sat_inc(perf_mispred_r);
            end
        end
    end

    // BTB and PHT update; lookup sees old contents in the update cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            btb_valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_r[i]    <= TAG_W'(0);
                btb_target_r[i] <= DATA_W'(0);
                pht_r[i]        <= 2'b01;
            end
        end else if (upd_valid) begin
            pht_r[upidx_s] <= sat2(pht_r[upidx_s], upd_taken);
            if (upd_taken) begin
                btb_valid_r[uidx_s]  <= 1'b1;
                btb_tag_r[uidx_s]    <= utag_s;
                btb_target_r[uidx_s] <= upd_target;
            end
        end
    end
endmodule
